wr_ctrl: RTL and testbench
==========================

WR_CTRL -- requirements
Module: wr_ctrl

Interface
REQ-001 SHALL have parameter W_DATA_WIDTH, default 16, write-port word width in bits.
REQ-002 SHALL have parameter MEM_WIDTH, default 16, FIFO memory word width in bits.
REQ-003 SHALL have parameter LIMIT, default 0, equal to log2(W_DATA_WIDTH/MEM_WIDTH).
REQ-004 SHALL have parameter ADDR_WIDTH, default 4; FIFO depth DEPTH = 2**ADDR_WIDTH memory words.
REQ-005 SHALL have parameter AF_MARGIN, default 2, almost-full margin in memory words.
REQ-006 SHALL have port clk, input, 1, single clock.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port wr_request, input, 1, producer requests one W_DATA_WIDTH write this cycle.
REQ-009 SHALL have port clear_ovf, input, 1, synchronous clear of overflow flag.
REQ-010 SHALL have port rd_ptr, input, ADDR_WIDTH+1, read pointer from read controller (MSB = wrap bit).
REQ-011 SHALL have port wr_ptr, output, ADDR_WIDTH+1, registered write pointer (MSB = wrap bit).
REQ-012 SHALL have port wr_en, output, 1, memory write strobe for the current cycle.
REQ-013 SHALL have port full_flag, output, 1, fewer than STEP free memory words.
REQ-014 SHALL have port almost_full, output, 1, fill level >= DEPTH - AF_MARGIN.
REQ-015 SHALL have port fill_level, output, ADDR_WIDTH+1, occupied memory words (0..DEPTH).
REQ-016 SHALL have port overflow, output, 1, sticky flag: write requested while full.

Function
REQ-017 SHALL define STEP = W_DATA_WIDTH/MEM_WIDTH; W_DATA_WIDTH SHALL be a power-of-two multiple of MEM_WIDTH, with LIMIT = log2(STEP) and LIMIT < ADDR_WIDTH.
REQ-018 SHALL compute fill_level combinationally as (wr_ptr - rd_ptr) modulo 2**(ADDR_WIDTH+1).
REQ-019 SHALL assert full_flag combinationally when DEPTH - fill_level < STEP; with STEP=1 this is wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH] and lower bits equal.
REQ-020 SHALL assert almost_full combinationally when fill_level >= DEPTH - AF_MARGIN (saturating at 0 if AF_MARGIN > DEPTH).
REQ-021 SHALL drive wr_en = wr_request AND NOT full_flag, combinationally (zero latency).
REQ-022 SHALL update wr_ptr on the rising edge of clk: wr_ptr <= wr_ptr + STEP when wr_en, else hold.
REQ-023 SHALL wrap wr_ptr modulo 2**(ADDR_WIDTH+1), toggling the MSB on each pass through DEPTH.
REQ-024 SHALL keep wr_ptr[LIMIT-1:0] at zero at all times when LIMIT > 0.
REQ-025 SHALL treat rd_ptr as same-clock-domain (read side updates on falling edge) with no synchronizer; rd_ptr changes take effect in flags within the same cycle.
REQ-026 SHALL set overflow on rising edge when wr_request AND full_flag; overflow SHALL remain set until clear_ovf or reset.
REQ-027 SHALL give set priority over clear when clear_ovf and an overflow event coincide.
REQ-028 SHALL never increment wr_ptr when full_flag is high, regardless of wr_request.
REQ-029 SHALL, on a cycle where a read frees space before the rising edge, accept the write if full_flag is low at that edge.

Reset
REQ-030 SHALL, while reset is high, asynchronously force wr_ptr = 0 and overflow = 0.
REQ-031 SHALL, with reset high and rd_ptr = 0, present fill_level = 0, full_flag = 0, almost_full = 0, wr_en = wr_request.
REQ-032 SHALL discard any in-flight write when reset asserts mid-operation; first write after release lands at address 0.

Verification (ADDR_WIDTH=4, DEPTH=16, AF_MARGIN=2 unless stated)
REQ-033 SHALL cover: STEP=1, rd_ptr=0, 16 consecutive wr_request -> wr_ptr 0..16 (0x10), full_flag=1 at wr_ptr=0x10, almost_full from wr_ptr=14.
REQ-034 SHALL cover: full, wr_request held 3 cycles -> wr_ptr stays 0x10, wr_en=0, overflow=1; clear_ovf pulse -> overflow=0.
REQ-035 SHALL cover: wrap, rd_ptr=0x1E, wr_ptr=0x1F, one write -> wr_ptr=0x00, fill_level=2.
REQ-036 SHALL cover: W_DATA_WIDTH=64, MEM_WIDTH=16, LIMIT=2, rd_ptr=0 -> wr_ptr steps 0,4,8,12,16; full_flag at fill 16; rd_ptr=4 then full_flag=0, next write accepted.
REQ-037 SHALL cover: reset asserted mid-burst at wr_ptr=7 -> wr_ptr=0 and overflow=0 immediately, before next clk edge.
REQ-038 SHALL cover: full with simultaneous read (rd_ptr 0->1 on falling edge) and wr_request -> write accepted at next rising edge, wr_ptr=0x11, overflow stays 0.

Source files
------------

// File: rtl/wr_ctrl.sv
// Write-side controller for a synchronous FIFO: owns the write pointer and
// derives fill level, full/almost-full flags, write strobe and sticky overflow.
module wr_ctrl #(
  parameter int W_DATA_WIDTH = 16,
  parameter int MEM_WIDTH    = 16,
  parameter int LIMIT        = 0,
  parameter int ADDR_WIDTH   = 4,
  parameter int AF_MARGIN    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_request,
  input  logic                  clear_ovf,
  input  logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  output logic                  wr_en,
  output logic                  full_flag,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow
);

  localparam int PW       = ADDR_WIDTH + 1;
  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int STEP     = W_DATA_WIDTH / MEM_WIDTH;
  localparam int AF_LEVEL = (AF_MARGIN > DEPTH) ? 0 : DEPTH - AF_MARGIN;

  localparam logic [PW-1:0] STEP_INC   = PW'(STEP);
  localparam logic [PW-1:0] LOW_MASK   = PW'((1 << LIMIT) - 1);
  // Fewer than STEP free words is the same as fill exceeding DEPTH - STEP.
  localparam logic [PW:0]   FULL_LEVEL = (PW+1)'(DEPTH - STEP);
  localparam logic [PW:0]   AF_THRESH  = (PW+1)'(AF_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] fill;
  logic          full;
  logic          ovf_q, ovf_d;

  assign fill = wr_ptr_q - rd_ptr;
  assign full = {1'b0, fill} > FULL_LEVEL;

  assign fill_level  = fill;
  assign full_flag   = full;
  assign almost_full = {1'b0, fill} >= AF_THRESH;
  assign wr_en       = wr_request & ~full;
  assign wr_ptr      = wr_ptr_q;
  assign overflow    = ovf_q;

  // Masking keeps the sub-word bits of the pointer pinned at zero for wide writes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q + STEP_INC) & ~LOW_MASK;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clear_ovf) begin
      ovf_d = 1'b0;
    end
    if (wr_request && full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_wr_ctrl.sv
// Bench for wr_ctrl: a single-word instance (dutA) and a 4-word-step instance
// (dutB) share the request lines and are compared against an integer word-count model.
module tb_wr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       wrRequest;
  logic       clearOvf;
  logic [4:0] rdPtrA, rdPtrB;

  logic [4:0] wrPtrA, fillA, wrPtrB, fillB;
  logic       wrEnA, fullA, afA, ovfA;
  logic       wrEnB, fullB, afB, ovfB;

  wr_ctrl #(
    .W_DATA_WIDTH(16), .MEM_WIDTH(16), .LIMIT(0), .ADDR_WIDTH(4), .AF_MARGIN(2)
  ) dutA (
    .clk(clk), .reset(reset), .wr_request(wrRequest), .clear_ovf(clearOvf),
    .rd_ptr(rdPtrA), .wr_ptr(wrPtrA), .wr_en(wrEnA), .full_flag(fullA),
    .almost_full(afA), .fill_level(fillA), .overflow(ovfA)
  );

  wr_ctrl #(
    .W_DATA_WIDTH(64), .MEM_WIDTH(16), .LIMIT(2), .ADDR_WIDTH(4), .AF_MARGIN(2)
  ) dutB (
    .clk(clk), .reset(reset), .wr_request(wrRequest), .clear_ovf(clearOvf),
    .rd_ptr(rdPtrB), .wr_ptr(wrPtrB), .wr_en(wrEnB), .full_flag(fullB),
    .almost_full(afB), .fill_level(fillB), .overflow(ovfB)
  );

  int   checks = 0;
  int   errors = 0;
  // Model: total memory words ever accepted, plus the sticky overflow flag.
  int   mWrA, mWrB;
  logic mOvfA, mOvfB;

  function automatic int fillOf(int wr, logic [4:0] rd);
    return ((wr % 32) - int'(rd) + 32) % 32;
  endfunction

  function automatic logic fullOf(int fill, int step);
    return (16 - fill) < step;
  endfunction

  // Expected {wr_ptr, fill_level, full, almost_full, wr_en, overflow}.
  function automatic logic [13:0] expVec(int wr, logic [4:0] rd, int step, logic req, logic ovf);
    int   f;
    logic fl;
    f  = fillOf(wr, rd);
    fl = fullOf(f, step);
    return {5'(wr % 32), 5'(f), fl, (f >= 14), req & ~fl, ovf};
  endfunction

  // Inputs change on the falling edge, like the read side.
  task automatic applyStimulus(input logic req, input logic clr, input logic [4:0] rA, input logic [4:0] rB);
    @(negedge clk);
    wrRequest = req;
    clearOvf  = clr;
    rdPtrA    = rA;
    rdPtrB    = rB;
    #1;
  endtask

  task automatic clockEdge();
    int fa, fb;
    logic fla, flb;
    fa  = fillOf(mWrA, rdPtrA);
    fb  = fillOf(mWrB, rdPtrB);
    fla = fullOf(fa, 1);
    flb = fullOf(fb, 4);
    if (!reset) begin
      if (wrRequest && !fla) mWrA += 1;
      if (wrRequest && !flb) mWrB += 4;
      mOvfA = (wrRequest && fla) ? 1'b1 : (clearOvf ? 1'b0 : mOvfA);
      mOvfB = (wrRequest && flb) ? 1'b1 : (clearOvf ? 1'b0 : mOvfB);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic holdReset();
    @(negedge clk);
    reset = 1'b1; wrRequest = 1'b1; clearOvf = 1'b0; rdPtrA = '0; rdPtrB = '0;
    mWrA = 0; mWrB = 0; mOvfA = 1'b0; mOvfB = 1'b0;
    #1;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset = 1'b0; wrRequest = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    holdReset();
    checks++;
    if ({wrPtrA, fillA, fullA, afA, wrEnA, ovfA} !== 14'b00000_00000_0_0_1_0) begin
      errors++;
      $display("[TB] FAIL reset_A got=%b want=%b", {wrPtrA, fillA, fullA, afA, wrEnA, ovfA}, 14'b00000_00000_0_0_1_0);
    end
    checks++;
    if ({wrPtrB, fillB, fullB, afB, wrEnB, ovfB} !== 14'b00000_00000_0_0_1_0) begin
      errors++;
      $display("[TB] FAIL reset_B got=%b want=%b", {wrPtrB, fillB, fullB, afB, wrEnB, ovfB}, 14'b00000_00000_0_0_1_0);
    end
    clockEdge();
    checks++;
    if (wrPtrA !== 5'd0 || wrPtrB !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_hold got=%h/%h want=0/0", wrPtrA, wrPtrB);
    end
    releaseReset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd0);
      checks++;
      if ({wrPtrA, fillA, fullA, afA, wrEnA, ovfA} !== expVec(mWrA, rdPtrA, 1, 1'b1, mOvfA)) begin
        errors++;
        $display("[TB] FAIL fill_A step=%0d got=%b want=%b", i, {wrPtrA, fillA, fullA, afA, wrEnA, ovfA}, expVec(mWrA, rdPtrA, 1, 1'b1, mOvfA));
      end
      checks++;
      if ({wrPtrB, fillB, fullB, afB, wrEnB, ovfB} !== expVec(mWrB, rdPtrB, 4, 1'b1, mOvfB)) begin
        errors++;
        $display("[TB] FAIL fill_B step=%0d got=%b want=%b", i, {wrPtrB, fillB, fullB, afB, wrEnB, ovfB}, expVec(mWrB, rdPtrB, 4, 1'b1, mOvfB));
      end
      clockEdge();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
    checks++;
    if (wrPtrA !== 5'h10 || fullA !== 1'b1 || afA !== 1'b1 || fillA !== 5'd16) begin
      errors++;
      $display("[TB] FAIL full_at_16 got ptr=%h full=%b af=%b fill=%0d want ptr=10 full=1 af=1 fill=16", wrPtrA, fullA, afA, fillA);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd0);
      checks++;
      if (wrEnA !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ovf_wren got=%b want=0", wrEnA);
      end
      clockEdge();
    end
    checks++;
    if (wrPtrA !== 5'h10 || ovfA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_set got ptr=%h ovf=%b want ptr=10 ovf=1", wrPtrA, ovfA);
    end
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0);
    clockEdge();
    checks++;
    if (ovfA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_set_priority got=%b want=1", ovfA);
    end
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0);
    clockEdge();
    checks++;
    if (ovfA !== 1'b0 || ovfB !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_clear got=%b/%b want=0/0", ovfA, ovfB);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic test_simul_read();
    applyStimulus(1'b1, 1'b0, 5'd1, 5'd4);
    checks++;
    if (fullA !== 1'b0 || wrEnA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_frees got full=%b wr_en=%b want 0/1", fullA, wrEnA);
    end
    clockEdge();
    checks++;
    if (wrPtrA !== 5'h11 || ovfA !== 1'b0 || wrPtrB !== 5'h14) begin
      errors++;
      $display("[TB] FAIL read_accept got ptrA=%h ovf=%b ptrB=%h want 11/0/14", wrPtrA, ovfA, wrPtrB);
    end
  endtask

  task automatic test_wrap();
    int guard = 0;
    while ((mWrA % 32) != 31 && guard < 64) begin
      applyStimulus(1'b1, 1'b0, 5'(mWrA - 1), 5'(mWrB));
      clockEdge();
      guard++;
    end
    checks++;
    if (wrPtrA !== 5'h1F) begin
      errors++;
      $display("[TB] FAIL wrap_reach got=%h want=1f", wrPtrA);
    end
    applyStimulus(1'b1, 1'b0, 5'h1E, 5'(mWrB));
    clockEdge();
    checks++;
    if (wrPtrA !== 5'h00 || fillA !== 5'd2) begin
      errors++;
      $display("[TB] FAIL wrap got ptr=%h fill=%0d want ptr=00 fill=2", wrPtrA, fillA);
    end
  endtask

  task automatic test_step4();
    logic [4:0] want;
    holdReset();
    releaseReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 5'(mWrA), 5'd0);
      want = 5'(4 * i);
      checks++;
      if (wrPtrB !== want || wrPtrB[1:0] !== 2'b00 || fullB !== (i == 4)) begin
        errors++;
        $display("[TB] FAIL step4 i=%0d got ptr=%h full=%b want ptr=%h full=%b", i, wrPtrB, fullB, want, (i == 4));
      end
      clockEdge();
    end
    applyStimulus(1'b1, 1'b0, 5'(mWrA), 5'd4);
    checks++;
    if (fullB !== 1'b0 || wrEnB !== 1'b1) begin
      errors++;
      $display("[TB] FAIL step4_free got full=%b wr_en=%b want 0/1", fullB, wrEnB);
    end
    clockEdge();
    checks++;
    if (wrPtrB !== 5'h14) begin
      errors++;
      $display("[TB] FAIL step4_accept got=%h want=14", wrPtrB);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    holdReset();
    releaseReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd0);
      clockEdge();
    end
    while ((mWrA % 32) != 7 && guard < 64) begin
      applyStimulus(1'b1, 1'b0, 5'(mWrA), 5'(mWrB));
      clockEdge();
      guard++;
    end
    checks++;
    if (wrPtrA !== 5'd7 || ovfA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_setup got ptr=%h ovf=%b want 07/1", wrPtrA, ovfA);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    mWrA = 0; mWrB = 0; mOvfA = 1'b0; mOvfB = 1'b0;
    #1;
    checks++;
    if (wrPtrA !== 5'd0 || ovfA !== 1'b0 || wrPtrB !== 5'd0 || ovfB !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset got ptr=%h/%h ovf=%b/%b want 0", wrPtrA, wrPtrB, ovfA, ovfB);
    end
    releaseReset();
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0);
    clockEdge();
    checks++;
    if (wrPtrA !== 5'd1 || wrPtrB !== 5'd4) begin
      errors++;
      $display("[TB] FAIL after_reset got ptr=%h/%h want 01/04", wrPtrA, wrPtrB);
    end
  endtask

  task automatic test_random();
    logic req, clr;
    for (int i = 0; i < 400; i++) begin
      req = ($urandom % 4) != 0;
      clr = ($urandom % 8) == 0;
      applyStimulus(req, clr, 5'(mWrA - int'($urandom_range(0, 16))), 5'(mWrB - int'($urandom_range(0, 16))));
      checks++;
      if ({wrPtrA, fillA, fullA, afA, wrEnA, ovfA} !== expVec(mWrA, rdPtrA, 1, req, mOvfA)) begin
        errors++;
        $display("[TB] FAIL rand_A i=%0d got=%b want=%b", i, {wrPtrA, fillA, fullA, afA, wrEnA, ovfA}, expVec(mWrA, rdPtrA, 1, req, mOvfA));
      end
      checks++;
      if ({wrPtrB, fillB, fullB, afB, wrEnB, ovfB} !== expVec(mWrB, rdPtrB, 4, req, mOvfB)) begin
        errors++;
        $display("[TB] FAIL rand_B i=%0d got=%b want=%b", i, {wrPtrB, fillB, fullB, afB, wrEnB, ovfB}, expVec(mWrB, rdPtrB, 4, req, mOvfB));
      end
      clockEdge();
    end
    checks++;
    if (wrPtrA !== 5'(mWrA % 32) || wrPtrB !== 5'(mWrB % 32) || ovfA !== mOvfA || ovfB !== mOvfB) begin
      errors++;
      $display("[TB] FAIL rand_final got ptr=%h/%h ovf=%b/%b want %h/%h %b/%b", wrPtrA, wrPtrB, ovfA, ovfB,
               5'(mWrA % 32), 5'(mWrB % 32), mOvfA, mOvfB);
    end
  endtask

  initial begin
    reset = 1'b1; wrRequest = 1'b0; clearOvf = 1'b0; rdPtrA = '0; rdPtrB = '0;
    mWrA = 0; mWrB = 0; mOvfA = 1'b0; mOvfB = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_simul_read();
    test_wrap();
    test_step4();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
